// File: rtl/data_store_pkg.sv
// data_store_pkg: sample-store address layout and readout FSM states.
// Shared by the writer and reader sides so {row, freq} is defined once.
package data_store_pkg;

    localparam int SYS_N_FREQ = 128;
    localparam int SYS_DEPTH  = 32;
    localparam int LOG_N      = $clog2(SYS_N_FREQ);
    localparam int LOG_D      = $clog2(SYS_DEPTH);
    localparam int ADDR_W     = LOG_N + LOG_D;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

endpackage

// File: rtl/readout_fifo.sv
// readout_fifo: first-word-fall-through FIFO with occupancy count; push and pop may coincide.
module readout_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/data_readout.sv
// data_readout: sweeps the sample store in {row, freq} order and streams it out as an
// AXI4-Stream master with full backpressure.
module data_readout
    import data_store_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_FREQ     = SYS_N_FREQ,
    parameter int DEPTH      = SYS_DEPTH,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(DEPTH):0]                 n_rows,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   rd_en,
    output logic [$clog2(N_FREQ)+$clog2(DEPTH)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]                  rd_data,
    output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tuser
);
    localparam int LN = $clog2(N_FREQ);
    localparam int LD = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    rd_state_t             state;
    logic [LN-1:0]         freq_cnt;
    logic [LD-1:0]         row_cnt;
    logic [LD:0]           rows;
    logic [RD_LATENCY-1:0] pend;
    logic [1:0]            tag [RD_LATENCY];
    logic [FW-1:0]         fcount;
    logic [CW-1:0]         inflight;
    logic [DATA_WIDTH+1:0] fdout;
    logic                  pop;
    logic                  row_end;
    logic                  read_end;
    logic                  drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pend[i]);
    end

    // A read is only issued when a FIFO slot is already reserved for its return word.
    assign rd_en    = (state == READ) && (inflight + CW'(fcount) + CW'(1) <= CW'(FIFO_DEPTH));
    assign rd_addr  = {row_cnt, freq_cnt};
    assign row_end  = &freq_cnt;
    assign read_end = row_end && ({1'b0, row_cnt} == rows - 1'b1);
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign drained  = pend == '0 && (fcount == '0 || (fcount == FW'(1) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rows     <= '0;
            row_cnt  <= '0;
            freq_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= READ;
                    busy     <= 1'b1;
                    rows     <= (n_rows == '0) ? (LD+1)'(DEPTH) : n_rows;
                    row_cnt  <= '0;
                    freq_cnt <= '0;
                end
                READ: if (rd_en) begin
                    freq_cnt <= freq_cnt + 1'b1;
                    if (row_end) row_cnt <= row_cnt + 1'b1;
                    if (read_end) state <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // {tlast, tuser} tags ride alongside the read pipeline so they meet their data word.
    always_ff @(posedge clk) begin
        pend[0] <= rst ? 1'b0 : rd_en;
        tag[0]  <= {row_end, read_end};
        for (int i = 1; i < RD_LATENCY; i++) begin
            pend[i] <= rst ? 1'b0 : pend[i-1];
            tag[i]  <= tag[i-1];
        end
    end

    readout_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend[RD_LATENCY-1]),
        .din   ({tag[RD_LATENCY-1], rd_data}),
        .pop   (pop),
        .dout  (fdout),
        .count (fcount)
    );

    assign m_axis_tvalid = fcount != '0;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? fdout : '0;

endmodule

// File: tb/tb_data_readout.sv
// tb_data_readout: two DUT lanes (RD_LATENCY 1 and 2) share one directed stimulus; each lane
// is scored every cycle by a queue model of the expected beat sequence.
module tb_data_readout;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tready  = 1'b1;
    logic [1:0] start_v = '0;
    logic [2:0] n_rows  = '0;
    int         cyc     = 0;
    int         pass_n  = 0;
    int         total_n = 0;
    bit         strict  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int g, logic [63:0] got, logic [63:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s lane%0d: got %0h, expected %0h (cycle %0d)", nm, g, got, exp, cyc);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = g + 1;
        logic        busy, done, rd_en, tvalid, tlast, tuser;
        logic [3:0]  rd_addr;
        logic [63:0] rd_data, tdata;
        logic [63:0] pipe [L];

        data_readout #(
            .DATA_WIDTH (64),
            .N_FREQ     (4),
            .DEPTH      (4),
            .RD_LATENCY (L),
            .FIFO_DEPTH (4)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start_v[g]),
            .n_rows        (n_rows),
            .busy          (busy),
            .done          (done),
            .rd_en         (rd_en),
            .rd_addr       (rd_addr),
            .rd_data       (rd_data),
            .m_axis_tdata  (tdata),
            .m_axis_tvalid (tvalid),
            .m_axis_tready (tready),
            .m_axis_tlast  (tlast),
            .m_axis_tuser  (tuser)
        );

        // Memory preloaded with data = address; non-read cycles return a marker word.
        always @(posedge clk) begin
            pipe[0] <= rd_en ? 64'(rd_addr) : 64'hDEAD_BEEF;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rd_data = pipe[L-1];

        bit          act, ndone, first, prst, hold, act_now, popped;
        int          iss, popn, total, sc, beats, dones, dcyc, scyc;
        int          q[$];
        logic [63:0] hd;

        always @(negedge clk) begin
            act_now = act;
            popped  = 1'b0;
            chk("busy", g, 64'(busy), 64'(act));
            chk("done", g, 64'(done), 64'(ndone));
            if (done) begin
                dones++;
                dcyc = cyc;
            end
            if (prst) begin
                chk("rst_tdata", g, tdata, '0);
                chk("rst_flags", g, 64'({tlast, tuser}), '0);
            end
            if (rd_en) begin
                chk("rd_addr", g, 64'(rd_addr), 64'(iss % 16));
                chk("rd_window", g, 64'(act && iss < total), 64'(1));
                chk("credit", g, 64'(iss - popn + 1 <= 4), 64'(1));
                iss++;
            end
            if (tvalid) begin
                if (q.size() == 0) chk("extra_beat", g, 64'(1), 64'(0));
                else begin
                    chk("tdata", g, tdata, 64'(q[0]));
                    chk("tlast", g, 64'(tlast), 64'(q[0] % 4 == 3));
                    chk("tuser", g, 64'(tuser), 64'(q[0] == total - 1));
                    if (!first) chk("latency", g, 64'(cyc - sc), 64'(L + 2));
                    first = 1'b1;
                    if (tready) begin
                        void'(q.pop_front());
                        popn++;
                        beats++;
                        popped = 1'b1;
                    end
                end
            end else if (strict && act && first && q.size() != 0) chk("gap", g, 64'(0), 64'(1));
            if (hold) begin
                chk("hold_valid", g, 64'(tvalid), 64'(1));
                chk("hold_data", g, tdata, hd);
            end
            hold  = tvalid && !tready;
            hd    = tdata;
            ndone = 1'b0;
            if (popped && q.size() == 0 && act) begin
                act   = 1'b0;
                ndone = 1'b1;
            end
            if (start_v[g] && !act_now && !rst) begin
                act   = 1'b1;
                total = 4 * ((n_rows == 3'd0) ? 4 : int'(n_rows));
                q.delete();
                for (int i = 0; i < total; i++) q.push_back(i);
                iss   = 0;
                popn  = 0;
                beats = 0;
                first = 1'b0;
                sc    = cyc;
                scyc  = cyc;
            end
            if (rst) begin
                act   = 1'b0;
                ndone = 1'b0;
                hold  = 1'b0;
                q.delete();
            end
            prst = rst;
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(string nm, int n0, int n1);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            ok = lane[0].dones >= n0 && lane[1].dones >= n1;
            if (!ok) step();
        end
        chk(nm, 0, 64'(ok), 64'(1));
    endtask

    // mode 0: tready high; 1: tready toggles; 2: 20-cycle stall; 3: extra start mid-readout
    task automatic run(string nm, int nr, int mode);
        int  b0 = lane[0].dones;
        int  b1 = lane[1].dones;
        bit  ok = 1'b0;
        strict  = mode == 0;
        start_v = 2'b11;
        n_rows  = 3'(nr);
        step();
        start_v = '0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (mode == 1) tready = ~tready;
            if (mode == 2) tready = !(i >= 5 && i < 25);
            if (mode == 2 && i == 24) begin
                chk({nm, "_stall_rd_en"}, 0, 64'(lane[0].rd_en), 64'(0));
                chk({nm, "_stall_rd_en"}, 1, 64'(lane[1].rd_en), 64'(0));
            end
            if (mode == 3) begin
                start_v = (i == 4) ? 2'b11 : 2'b00;
                if (i == 4) n_rows = 3'd1;
            end
            step();
            ok = lane[0].dones > b0 && lane[1].dones > b1;
        end
        start_v = '0;
        tready  = 1'b1;
        strict  = 1'b0;
        chk({nm, "_finish"}, 0, 64'(ok), 64'(1));
    endtask

    task automatic post(string nm, int nb, int d0);
        chk({nm, "_beats"}, 0, 64'(lane[0].beats), 64'(nb));
        chk({nm, "_beats"}, 1, 64'(lane[1].beats), 64'(nb));
        if (d0 > 0) begin
            chk({nm, "_done_at"}, 0, 64'(lane[0].dcyc - lane[0].scyc), 64'(d0));
            chk({nm, "_done_at"}, 1, 64'(lane[1].dcyc - lane[1].scyc), 64'(d0 + 1));
        end
    endtask

    initial begin
        int b0, b1, e0, e1;
        bit s0, s1;
        step(3);
        rst = 1'b0;
        step();
        chk("reset_busy", 0, 64'(lane[0].busy), 64'(0));
        chk("reset_tvalid", 1, 64'(lane[1].tvalid), 64'(0));
        chk("reset_rd_en", 0, 64'(lane[0].rd_en), 64'(0));
        chk("reset_rd_addr", 1, 64'(lane[1].rd_addr), 64'(0));

        run("t1", 2, 0);
        post("t1", 8, 11);
        run("t2", 0, 0);
        post("t2", 16, 19);
        run("t3", 2, 1);
        post("t3", 8, 0);
        run("t3s", 4, 2);
        post("t3s", 16, 0);
        run("t4", 2, 3);
        post("t4", 8, 11);

        start_v = 2'b11;
        n_rows  = 3'd2;
        step();
        start_v = '0;
        for (int i = 0; i < 100 && lane[0].beats < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        b0  = lane[0].dones;
        b1  = lane[1].dones;
        step();
        chk("t5_busy", 0, 64'(lane[0].busy), 64'(0));
        chk("t5_tvalid", 1, 64'(lane[1].tvalid), 64'(0));
        step(10);
        chk("t5_no_done", 0, 64'(lane[0].dones), 64'(b0));
        chk("t5_no_done", 1, 64'(lane[1].dones), 64'(b1));
        run("t5", 1, 0);
        post("t5", 4, 7);

        b0      = lane[0].dones;
        b1      = lane[1].dones;
        s0      = 1'b0;
        s1      = 1'b0;
        strict  = 1'b1;
        start_v = 2'b11;
        n_rows  = 3'd1;
        step();
        for (int i = 0; i < 200 && !(s0 && s1); i++) begin
            start_v = '0;
            if (!s0 && lane[0].dones > b0) begin
                start_v[0] = 1'b1;
                s0 = 1'b1;
                e0 = lane[0].dcyc;
            end
            if (!s1 && lane[1].dones > b1) begin
                start_v[1] = 1'b1;
                s1 = 1'b1;
                e1 = lane[1].dcyc;
            end
            step();
        end
        start_v = '0;
        chk("t6_restart", 0, 64'(s0 && s1), 64'(1));
        wait_dones("t6_finish", b0 + 2, b1 + 2);
        strict = 1'b0;
        chk("t6_start_after_done", 0, 64'(lane[0].scyc - e0), 64'(1));
        chk("t6_start_after_done", 1, 64'(lane[1].scyc - e1), 64'(1));
        post("t6", 4, 7);

        step(3);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks made", total_n);
        $fatal(1, "watchdog");
    end

endmodule
